dmni_packetizer: RTL and testbench
==================================

DMNI_PACKETIZER -- requirements
Module: dmni_packetizer

Interface
REQ-001 Parameter FLIT_SIZE, default 32, is the width of data_o, of the header field inputs and of pl_data_i.
REQ-002 Parameter HDR_FLITS, default 7, is the number of header flits per packet; it is fixed, not configurable in use.
REQ-003 clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  1  message request valid.
REQ-006 req_ready_o  output  1  request accepted when req_i && req_ready_o.
REQ-007 target_i  input  16  destination address, X in [15:8] and Y in [7:0].
REQ-008 service_i, producer_i, consumer_i  input  FLIT_SIZE each  header fields.
REQ-009 payload_len_i  input  16  number of payload flits, 0 is legal.
REQ-010 pl_valid_i / pl_ready_o / pl_data_i  in / out / in FLIT_SIZE  payload stream.
REQ-011 tx_o  output  1  flit valid toward the NoC.
REQ-012 eop_o  output  1  marks the last flit of a packet.
REQ-013 credit_i  input  1  NoC can accept a flit; a flit transfers when tx_o && credit_i.
REQ-014 data_o  output  FLIT_SIZE  flit data.
REQ-015 tick_cntr_i  input  64  free-running tick counter.
REQ-016 busy_o  output  1  high from request acceptance until the eop flit transfers.

Function
REQ-017 The block SHALL have the states IDLE, HEADER and PAYLOAD.
REQ-018 req_ready_o SHALL be 1 exactly when the state is IDLE.
REQ-019 On request acceptance at cycle T, the block SHALL register all header fields and tick_cntr_i[31:0] (the timestamp), set flit_cnt to 0 and enter HEADER; tx_o SHALL first be high at T+1.
REQ-020 Header flit order (index: content):
- 0: {zero-extend, target_i}
- 1: size = 5 + payload_len, computed in FLIT_SIZE bits, no overflow possible
- 2: service
- 3: producer
- 4: consumer
- 5: payload_len, zero-extended
- 6: timestamp
REQ-021 In HEADER, tx_o SHALL be 1 and data_o SHALL be the registered field for flit_cnt; data_o SHALL stay stable while credit_i is 0.
REQ-022 In HEADER, flit_cnt SHALL increment only on a transfer.
REQ-023 A transfer of flit 6 SHALL enter PAYLOAD when payload_len>0, and IDLE when payload_len==0; in the latter case eop_o SHALL be 1 on flit 6.
REQ-024 In PAYLOAD, the payload path SHALL be combinational pass-through: tx_o=pl_valid_i, pl_ready_o=credit_i, data_o=pl_data_i.
REQ-025 In PAYLOAD, a down-counter loaded with payload_len SHALL decrement on each transfer.
REQ-026 In PAYLOAD, eop_o=tx_o when the counter is 1; that transfer SHALL return the block to IDLE.
REQ-027 Outside PAYLOAD, pl_ready_o SHALL be 0.
REQ-028 In IDLE, tx_o, eop_o and data_o SHALL be 0.
REQ-029 The total number of flits transferred per packet SHALL equal 7 + payload_len.
REQ-030 A request presented on the same cycle as an eop transfer SHALL NOT be accepted until the following cycle (IDLE); there SHALL be no back-to-back packet overlap.
REQ-031 A payload_len of 65535 SHALL work, with the down-counter 16 bits wide and no wrap.
REQ-032 The timestamp SHALL be the tick counter truncated to 32 bits; wrap of the tick counter is not treated specially.

Reset
REQ-033 While rst_ni is 0, the state SHALL be IDLE, all counters and registered fields 0, and tx_o, eop_o, pl_ready_o, busy_o and data_o 0; req_ready_o SHALL be 1.
REQ-034 Reset asserted mid-packet SHALL abort the packet immediately; no eop is issued, and the first cycle after release is IDLE.

Verification
REQ-035 Request target=0x0102, service=0x1, producer=0xA, consumer=0xB, len=2, tick=100, credit always 1 -> 9 consecutive flits from T+1: 0x102, 7, 1, 0xA, 0xB, 2, 100, P0, P1; eop only on P1; busy_o is low the cycle after P1.
REQ-036 len=0 -> 7 flits with eop on the timestamp flit; pl_ready_o never asserts.
REQ-037 credit_i toggles 1,0,1,0 during the header -> each flit is held stable while blocked; no flit is duplicated or dropped; order is intact.
REQ-038 In PAYLOAD with pl_valid_i=0 for 5 cycles -> tx_o=0 and no count change; the packet resumes correctly.
REQ-039 rst_ni pulsed low during flit 4 -> all outputs 0 immediately; the next request sends a complete, correct packet.
REQ-040 req_i held high continuously with len=1 -> packets are separated by exactly one IDLE cycle; each packet's timestamp equals the tick value at its acceptance.

Source files
------------

// File: rtl/dmni_packetizer.sv
// -----------------------------------------------------------------------------
// dmni_packetizer
//
// Turns a message request into a NoC packet: seven header flits built from
// registered request fields, followed by payload_len payload flits streamed
// straight from the payload interface. The last flit of every packet carries
// eop_o.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i / req_ready_o  message request handshake (ready only in IDLE)
//   target_i             destination address {X[15:8], Y[7:0]}
//   service_i            header field: service
//   producer_i           header field: producer
//   consumer_i           header field: consumer
//   payload_len_i        number of payload flits (0 is legal)
//   pl_valid_i/pl_ready_o/pl_data_i  payload stream in
//   tx_o, eop_o, data_o  flit out toward the NoC
//   credit_i             NoC can accept a flit (transfer = tx_o && credit_i)
//   tick_cntr_i          free-running tick counter, low 32 bits timestamp
//   busy_o               a packet is in flight
// -----------------------------------------------------------------------------
module dmni_packetizer #(
    parameter int FLIT_SIZE = 32,
    parameter int HDR_FLITS = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 req_ready_o,
    input  logic [15:0]          target_i,
    input  logic [FLIT_SIZE-1:0] service_i,
    input  logic [FLIT_SIZE-1:0] producer_i,
    input  logic [FLIT_SIZE-1:0] consumer_i,
    input  logic [15:0]          payload_len_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    output logic                 eop_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic [63:0]          tick_cntr_i,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(HDR_FLITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Registered request fields
    logic [15:0]          target_q;
    logic [15:0]          len_q;
    logic [FLIT_SIZE-1:0] service_q;
    logic [FLIT_SIZE-1:0] producer_q;
    logic [FLIT_SIZE-1:0] consumer_q;
    logic [31:0]          ts_q;

    logic [CNT_W-1:0]     flit_cnt;   // header flit index
    logic [15:0]          pay_cnt;    // payload flits still to send

    logic                 accept;
    logic                 hdr_xfer;
    logic                 pl_xfer;
    logic                 hdr_last;
    logic [FLIT_SIZE-1:0] hdr_data;

    // Only the low 32 bits of the tick counter form the timestamp.
    logic                 unused_tick_hi;
    assign unused_tick_hi = ^tick_cntr_i[63:32];

    assign accept   = req_i && (state == IDLE);
    assign hdr_xfer = (state == HEADER) && credit_i;
    assign pl_xfer  = (state == PAYLOAD) && pl_valid_i && credit_i;
    assign hdr_last = (flit_cnt == CNT_W'(HDR_FLITS - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i) state_nxt = HEADER;
            end
            HEADER: begin
                // Zero-length packets end on the timestamp flit.
                if (hdr_xfer && hdr_last) begin
                    if (len_q == 16'd0) state_nxt = IDLE;
                    else                state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pl_xfer && (pay_cnt == 16'd1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q   <= '0;
            len_q      <= '0;
            service_q  <= '0;
            producer_q <= '0;
            consumer_q <= '0;
            ts_q       <= '0;
            flit_cnt   <= '0;
            pay_cnt    <= '0;
        end else if (accept) begin
            target_q   <= target_i;
            len_q      <= payload_len_i;
            service_q  <= service_i;
            producer_q <= producer_i;
            consumer_q <= consumer_i;
            ts_q       <= tick_cntr_i[31:0];
            flit_cnt   <= '0;
            pay_cnt    <= payload_len_i;
        end else if (hdr_xfer) begin
            flit_cnt   <= flit_cnt + CNT_W'(1);
        end else if (pl_xfer) begin
            pay_cnt    <= pay_cnt - 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Header flit selection
    // -------------------------------------------------------------------------
    always_comb begin
        hdr_data = '0;
        case (flit_cnt)
            CNT_W'(0): hdr_data = FLIT_SIZE'(target_q);
            // Size counts the header flits after the size flit itself.
            CNT_W'(1): hdr_data = FLIT_SIZE'(len_q) + FLIT_SIZE'(5);
            CNT_W'(2): hdr_data = service_q;
            CNT_W'(3): hdr_data = producer_q;
            CNT_W'(4): hdr_data = consumer_q;
            CNT_W'(5): hdr_data = FLIT_SIZE'(len_q);
            CNT_W'(6): hdr_data = FLIT_SIZE'(ts_q);
            default:   hdr_data = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready_o = 1'b0;
        tx_o        = 1'b0;
        eop_o       = 1'b0;
        pl_ready_o  = 1'b0;
        data_o      = '0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
            end
            HEADER: begin
                tx_o   = 1'b1;
                data_o = hdr_data;
                eop_o  = hdr_last && (len_q == 16'd0);
            end
            PAYLOAD: begin
                // Payload is a pure pass-through; the NoC credit is the
                // payload ready.
                tx_o       = pl_valid_i;
                pl_ready_o = credit_i;
                data_o     = pl_data_i;
                eop_o      = pl_valid_i && (pay_cnt == 16'd1);
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmni_packetizer.sv
// -----------------------------------------------------------------------------
// tb_dmni_packetizer
//
// Self-checking bench for dmni_packetizer. Inputs are driven on the falling
// edge and outputs sampled 1 ns later; a directed vector table covers the
// basic packet cycle by cycle, and hand-written sequences cover zero-length
// packets, credit back-pressure, payload gaps, reset abort and back-to-back
// requests.
// -----------------------------------------------------------------------------
module tb_dmni_packetizer;

    localparam int          FS      = 32;
    localparam logic [31:0] PL_BASE = 32'hC0DE_0000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_i;
    logic          req_ready_o;
    logic [15:0]   target_i;
    logic [FS-1:0] service_i;
    logic [FS-1:0] producer_i;
    logic [FS-1:0] consumer_i;
    logic [15:0]   payload_len_i;
    logic          pl_valid_i;
    logic          pl_ready_o;
    logic [FS-1:0] pl_data_i;
    logic          tx_o;
    logic          eop_o;
    logic          credit_i;
    logic [FS-1:0] data_o;
    logic [63:0]   tick;
    logic          busy_o;

    dmni_packetizer #(.FLIT_SIZE(FS), .HDR_FLITS(7)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .req_ready_o   (req_ready_o),
        .target_i      (target_i),
        .service_i     (service_i),
        .producer_i    (producer_i),
        .consumer_i    (consumer_i),
        .payload_len_i (payload_len_i),
        .pl_valid_i    (pl_valid_i),
        .pl_ready_o    (pl_ready_o),
        .pl_data_i     (pl_data_i),
        .tx_o          (tx_o),
        .eop_o         (eop_o),
        .credit_i      (credit_i),
        .data_o        (data_o),
        .tick_cntr_i   (tick),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge; the tick counter moves once per cycle.
    task automatic next_cycle();
        @(negedge clk_i);
        tick = tick + 64'd1;
    endtask

    // -------------------------------------------------------------------------
    // Flit monitor: records every transfer and checks blocked flits are held.
    // -------------------------------------------------------------------------
    logic [32:0] fq[$];
    int          xfers;
    logic        blocked_prev;
    logic [31:0] blocked_data;
    logic        plr_seen;

    task automatic mon_reset();
        fq.delete();
        xfers        = 0;
        blocked_prev = 1'b0;
        blocked_data = '0;
        plr_seen     = 1'b0;
    endtask

    task automatic mon();
        if (blocked_prev) begin
            check("hold_tx", {31'd0, tx_o}, 32'd1);
            check("hold_data", data_o, blocked_data);
        end
        blocked_prev = tx_o && !credit_i;
        blocked_data = data_o;
        if (pl_ready_o) plr_seen = 1'b1;
        if (tx_o && credit_i) begin
            fq.push_back({eop_o, data_o});
            xfers++;
        end
    endtask

    // Compare the captured flits with the packet the bench expects.
    task automatic cmp_packet(input string tag, input logic [15:0] len, input logic [31:0] ts);
        logic [31:0] hdr [7];
        logic [31:0] exp_d;
        int          total;
        total  = 7 + int'(len);
        hdr[0] = {16'd0, target_i};
        hdr[1] = 32'(len) + 32'd5;
        hdr[2] = service_i;
        hdr[3] = producer_i;
        hdr[4] = consumer_i;
        hdr[5] = 32'(len);
        hdr[6] = ts;
        check($sformatf("%s_count", tag), 32'(fq.size()), 32'(total));
        for (int i = 0; i < fq.size() && i < total; i++) begin
            exp_d = (i < 7) ? hdr[i] : PL_BASE + 32'(i - 7);
            check($sformatf("%s_data%0d", tag, i), fq[i][31:0], exp_d);
            check($sformatf("%s_eop%0d", tag, i), {31'd0, fq[i][32]}, {31'd0, i == total - 1});
        end
    endtask

    // One packet: credit_mode toggles credit 1,0,1,0... over the header,
    // gap drops pl_valid for 5 cycles after the first payload flit.
    task automatic run_pkt(input string tag, input logic [15:0] len,
                           input bit credit_mode, input bit gap);
        logic [31:0] ts;
        bit          done;
        int          gaps;
        payload_len_i = len;
        mon_reset();
        done = 0;
        gaps = 0;
        next_cycle();
        req_i      = 1'b1;
        credit_i   = 1'b1;
        pl_valid_i = 1'b0;
        #1;
        check({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
        ts = tick[31:0];
        mon();
        for (int k = 0; k < int'(len) + 40 && !done; k++) begin
            next_cycle();
            req_i      = 1'b0;
            credit_i   = (credit_mode && k < 10) ? (k % 2 == 0) : 1'b1;
            pl_data_i  = PL_BASE + 32'(xfers - 7);
            pl_valid_i = 1'b1;
            if (gap && xfers == 8 && gaps < 5) begin
                pl_valid_i = 1'b0;
                gaps++;
            end
            #1;
            if (!pl_valid_i) check({tag, "_gap_tx"}, {31'd0, tx_o}, 32'd0);
            if (tx_o && credit_i && eop_o) done = 1;
            mon();
        end
        check({tag, "_finished"}, {31'd0, done}, 32'd1);
        next_cycle();
        pl_valid_i = 1'b0;
        #1;
        check({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, req_ready_o}, 32'd1);
        cmp_packet(tag, len, ts);
        check({tag, "_pl_ready_seen"}, {31'd0, plr_seen}, {31'd0, len != 16'd0});
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table for the basic 2-payload packet
    // -------------------------------------------------------------------------
    typedef struct {
        logic        req;
        logic        credit;
        logic        pl_valid;
        logic [31:0] pl_data;
        logic        tx;
        logic        eop;
        logic [31:0] data;
        logic        plr;
        logic        busy;
        logic        rr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        rst_ni        = 1'b0;
        req_i         = 1'b1;
        credit_i      = 1'b1;
        pl_valid_i    = 1'b1;
        pl_data_i     = 32'h1234_5678;
        target_i      = 16'h0102;
        service_i     = 32'h1;
        producer_i    = 32'hA;
        consumer_i    = 32'hB;
        payload_len_i = 16'd2;
        tick          = 64'd0;

        // Reset state, even with requests and payload offered
        repeat (2) next_cycle();
        #1;
        check("rst_tx",        {31'd0, tx_o},        32'd0);
        check("rst_eop",       {31'd0, eop_o},       32'd0);
        check("rst_data",      data_o,               32'd0);
        check("rst_pl_ready",  {31'd0, pl_ready_o},  32'd0);
        check("rst_busy",      {31'd0, busy_o},      32'd0);
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        req_i      = 1'b0;
        pl_valid_i = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Basic packet, cycle by cycle: req at T with tick=100, credit always 1
        //           req   cred  pv    pl_data        tx    eop   data           plr   busy  rr
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h102,       1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'hDEAD,      1'b1, 1'b0, 32'd7,         1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'hDEAD,      1'b1, 1'b0, 32'h1,         1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'hDEAD,      1'b1, 1'b0, 32'hA,         1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'hB,         1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'd2,         1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'd100,       1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0000, 1'b1, 1'b0, 32'hC0DE_0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0001, 1'b1, 1'b1, 32'hC0DE_0001, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            next_cycle();
            if (i == 0) tick = 64'd100;
            req_i      = vecs[i].req;
            credit_i   = vecs[i].credit;
            pl_valid_i = vecs[i].pl_valid;
            pl_data_i  = vecs[i].pl_data;
            #1;
            check($sformatf("v%0d_tx", i),        {31'd0, tx_o},        {31'd0, vecs[i].tx});
            check($sformatf("v%0d_eop", i),       {31'd0, eop_o},       {31'd0, vecs[i].eop});
            check($sformatf("v%0d_data", i),      data_o,               vecs[i].data);
            check($sformatf("v%0d_pl_ready", i),  {31'd0, pl_ready_o},  {31'd0, vecs[i].plr});
            check($sformatf("v%0d_busy", i),      {31'd0, busy_o},      {31'd0, vecs[i].busy});
            check($sformatf("v%0d_req_ready", i), {31'd0, req_ready_o}, {31'd0, vecs[i].rr});
        end

        // Zero-length packet: eop on the timestamp flit, no payload ready
        target_i   = 16'h0304;
        service_i  = 32'h2;
        producer_i = 32'h3;
        consumer_i = 32'h4;
        run_pkt("len0", 16'd0, 1'b0, 1'b0);

        // Credit toggling during the header
        target_i   = 16'h0A0B;
        service_i  = 32'h5555_0001;
        producer_i = 32'h6666_0002;
        consumer_i = 32'h7777_0003;
        run_pkt("credit", 16'd3, 1'b1, 1'b0);

        // Payload gap of 5 cycles, with a length past 8 bits
        target_i   = 16'hFF00;
        service_i  = 32'hFFFF_FFFF;
        producer_i = 32'h0;
        consumer_i = 32'h8000_0000;
        run_pkt("gap", 16'd300, 1'b0, 1'b1);

        // Reset pulse while flit 4 is on the output
        begin
            bit hit;
            hit = 0;
            payload_len_i = 16'd3;
            mon_reset();
            next_cycle();
            req_i    = 1'b1;
            credit_i = 1'b1;
            #1;
            mon();
            for (int k = 0; k < 20 && !hit; k++) begin
                next_cycle();
                req_i = 1'b0;
                #1;
                if (xfers == 4 && tx_o) begin
                    hit    = 1;
                    rst_ni = 1'b0;
                    #1;
                    check("abort_tx",        {31'd0, tx_o},        32'd0);
                    check("abort_eop",       {31'd0, eop_o},       32'd0);
                    check("abort_data",      data_o,               32'd0);
                    check("abort_busy",      {31'd0, busy_o},      32'd0);
                    check("abort_pl_ready",  {31'd0, pl_ready_o},  32'd0);
                    check("abort_req_ready", {31'd0, req_ready_o}, 32'd1);
                end else begin
                    mon();
                end
            end
            check("abort_reached_flit4", {31'd0, hit}, 32'd1);
            next_cycle();
            rst_ni = 1'b1;
            #1;
            check("abort_idle_tx",    {31'd0, tx_o},        32'd0);
            check("abort_idle_ready", {31'd0, req_ready_o}, 32'd1);
            target_i   = 16'h0201;
            service_i  = 32'h9;
            producer_i = 32'h8;
            consumer_i = 32'h7;
            run_pkt("after_rst", 16'd2, 1'b0, 1'b0);
        end

        // req held high, len=1: one IDLE cycle between packets, fresh timestamps
        begin
            int          acc_cyc [$];
            logic [31:0] acc_ts  [$];
            int          eop_cyc [$];
            logic [31:0] ts_seen [$];
            int          idx;
            tick          = 64'hABCD_0001_FFFF_FFF8;
            payload_len_i = 16'd1;
            pl_valid_i    = 1'b1;
            pl_data_i     = 32'h55;
            credit_i      = 1'b1;
            idx           = 0;
            for (int c = 0; c < 40 && eop_cyc.size() < 2; c++) begin
                next_cycle();
                req_i = 1'b1;
                #1;
                if (req_i && req_ready_o) begin
                    acc_cyc.push_back(c);
                    acc_ts.push_back(tick[31:0]);
                end
                if (tx_o && credit_i) begin
                    if (idx == 6) ts_seen.push_back(data_o);
                    idx++;
                    if (eop_o) begin
                        eop_cyc.push_back(c);
                        check("b2b_ready_at_eop", {31'd0, req_ready_o}, 32'd0);
                        idx = 0;
                    end
                end
            end
            next_cycle();
            req_i      = 1'b0;
            pl_valid_i = 1'b0;
            check("b2b_eops",    32'(eop_cyc.size()), 32'd2);
            check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
            if (eop_cyc.size() == 2 && acc_cyc.size() == 2 && ts_seen.size() == 2) begin
                check("b2b_gap",  32'(acc_cyc[1]), 32'(eop_cyc[0] + 1));
                check("b2b_len",  32'(eop_cyc[0] - acc_cyc[0]), 32'd8);
                check("b2b_ts0",  ts_seen[0], acc_ts[0]);
                check("b2b_ts1",  ts_seen[1], acc_ts[1]);
            end else begin
                check("b2b_sequence_complete", 32'd0, 32'd1);
            end
            #1;
            check("b2b_idle_after", {31'd0, busy_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
